interrupt_vector_loader: RTL

INTERRUPT_VECTOR_LOADER -- requirements
Module: interrupt_vector_loader

---
 rtl/interrupt_vector_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/interrupt_vector_loader.sv
// Loads a 32-bit interrupt service routine address from two consecutive 16-bit
// instruction-memory words and redirects the fetch-stage PC to it.
module interrupt_vector_loader #(
    parameter logic [31:0] IVT_BASE = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        interruptRaisedToFetch,
    input  logic        imemReady,
    input  logic [15:0] imemData,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic        fetchStall,
    output logic        pcLoad,
    output logic [31:0] pcLoadValue,
    output logic        busy,
    output logic        vecError
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [31:0] IVT_LO_ADDR = IVT_BASE + 32'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_HI = 2'd1,
        RD_LO = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t           state;
    logic             irqPrev;
    logic             sampleValid;
    logic             pending;
    logic [CNT_W-1:0] waitCnt;
    logic [15:0]      hiWord;

    logic startEvt;
    logic wordTimeout;

    // sampleValid masks the first cycle after reset so a level already high is not an edge
    assign startEvt    = sampleValid & interruptRaisedToFetch & ~irqPrev;
    assign wordTimeout = (waitCnt == TIMEOUT_CNT) & ~imemReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            irqPrev     <= 1'b0;
            sampleValid <= 1'b0;
            pending     <= 1'b0;
            waitCnt     <= '0;
            hiWord      <= '0;
            imemReq     <= 1'b0;
            imemAddr    <= IVT_BASE;
            fetchStall  <= 1'b0;
            pcLoad      <= 1'b0;
            pcLoadValue <= '0;
            busy        <= 1'b0;
            vecError    <= 1'b0;
        end else begin
            irqPrev     <= interruptRaisedToFetch;
            sampleValid <= 1'b1;
            pcLoad      <= 1'b0;
            vecError    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (startEvt) begin
                        state      <= RD_HI;
                        imemReq    <= 1'b1;
                        imemAddr   <= IVT_BASE;
                        fetchStall <= 1'b1;
                        busy       <= 1'b1;
                        waitCnt    <= '0;
                    end
                end

                RD_HI: begin
                    if (startEvt) begin
                        pending <= 1'b1;
                    end
                    if (imemReady) begin
                        hiWord   <= imemData;
                        waitCnt  <= '0;
                        imemAddr <= IVT_LO_ADDR;
                        state    <= RD_LO;
                    end else if (wordTimeout) begin
                        state      <= IDLE;
                        imemReq    <= 1'b0;
                        fetchStall <= 1'b0;
                        busy       <= 1'b0;
                        vecError   <= 1'b1;
                        pending    <= 1'b0;
                        waitCnt    <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end

                RD_LO: begin
                    if (startEvt) begin
                        pending <= 1'b1;
                    end
                    // Low word goes straight into the PC value; no separate capture register needed
                    if (imemReady) begin
                        pcLoad      <= 1'b1;
                        pcLoadValue <= {hiWord, imemData};
                        imemReq     <= 1'b0;
                        waitCnt     <= '0;
                        state       <= LOAD;
                    end else if (wordTimeout) begin
                        state      <= IDLE;
                        imemReq    <= 1'b0;
                        fetchStall <= 1'b0;
                        busy       <= 1'b0;
                        vecError   <= 1'b1;
                        pending    <= 1'b0;
                        waitCnt    <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end

                LOAD: begin
                    // An edge landing in this cycle behaves as if it had been pending already
                    if (pending || startEvt) begin
                        state    <= RD_HI;
                        pending  <= 1'b0;
                        imemReq  <= 1'b1;
                        imemAddr <= IVT_BASE;
                        waitCnt  <= '0;
                    end else begin
                        state      <= IDLE;
                        fetchStall <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
